// File: rtl/myfunction_pkg.sv
// Shared AES helpers: S-box, SubWord/RotWord/Rcon and the key-schedule FSM state type.
package myfunction;

  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } ks_state_e;

  localparam logic [7:0] S_BOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] SubWord(input logic [31:0] w);
    return {S_BOX[w[31:24]], S_BOX[w[23:16]], S_BOX[w[15:8]], S_BOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] RotWord(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Out-of-range rounds yield zero so a stray selector can never inject a constant.
  function automatic logic [31:0] Rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One AES-128 key-expansion step: derives round key `round` from the previous round key.
module aes128_key_step
  import myfunction::*;
(
  input  logic [127:0] key_i,
  input  logic [3:0]   round_i,
  output logic [127:0] key_o
);

  logic [3:0][31:0] w_in;
  logic [3:0][31:0] w_out;
  logic [31:0]      t;

  assign w_in     = key_i;
  assign t        = SubWord(RotWord(w_in[0])) ^ Rcon(round_i);
  // Packed index 3 is word 0 (MSBs); each new word chains off the previously produced one.
  assign w_out[3] = w_in[3] ^ t;

  for (genvar i = 2; i >= 0; i--) begin : g_chain
    assign w_out[i] = w_in[i] ^ w_out[i+1];
  end

  assign key_o = w_out;

endmodule

// File: rtl/aes128_key_sched_ctrl.sv
// AES-128 key schedule controller: streams round keys 0..10 over a valid/ready handshake.
module aes128_key_sched_ctrl
  import myfunction::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [127:0] key_i,
  input  logic         rk_ready_i,
  output logic         rk_valid_o,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_idx_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  ks_state_e    state_q;
  logic [127:0] key_q;
  logic [127:0] key_d;
  logic [3:0]   idx_q;
  logic [3:0]   rnd_sel;
  logic         vld_q, busy_q, done_q;
  logic         xfer;

  // Saturate so the Rcon selector stays within 1..10 even while the last key is presented.
  assign rnd_sel = (idx_q < LAST_IDX) ? idx_q + 4'd1 : LAST_IDX;
  assign xfer    = vld_q & rk_ready_i;

  aes128_key_step u_step (
    .key_i  (key_q),
    .round_i(rnd_sel),
    .key_o  (key_d)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort_i) begin
      state_q <= ST_IDLE;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            key_q   <= key_i;
            idx_q   <= '0;
            vld_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (xfer) begin
            if (idx_q == LAST_IDX) begin
              vld_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              key_q <= key_d;
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          vld_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rk_valid_o = vld_q;
  assign rk_o       = key_q;
  assign rk_idx_o   = idx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Bench for the key schedule controller; reference keys come from a GF(2^8) arithmetic model.
module tb_aes128_key_sched_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_ni, start_i, abort_i, rk_ready_i;
  logic [127:0] key_i;
  logic         rk_valid_o, busy_o, done_o;
  logic [127:0] rk_o;
  logic [3:0]   rk_idx_o;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

  aes128_key_sched_ctrl dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .key_i     (key_i),
    .rk_ready_i(rk_ready_i),
    .rk_valid_o(rk_valid_o),
    .rk_o      (rk_o),
    .rk_idx_o  (rk_idx_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, x);
    return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One expansion: ready asserted with probability pct%; optional abort/reset at stop_at, optional stray start at start_at.
  task automatic run(input logic [127:0] key, input int pct, input int stop_at,
                     input int stop_kind, input int start_at);
    int idx;
    int cyc;
    bit fin;
    bit rdy;
    bit pulsed;
    expand(key);
    for (int i = 0; i < 11; i++) got_rk[i] = '0;
    abort_i = 1'b0; rk_ready_i = 1'b0; start_i = 1'b1; key_i = key;
    tick();
    start_i = 1'b0; key_i = rnd128();
    idx = 0; cyc = 0; fin = 1'b0; pulsed = 1'b0;
    while (!fin && cyc < 500) begin
      chk("emit_valid", 128'(rk_valid_o), 128'd1);
      chk("emit_idx", 128'(rk_idx_o), 128'(idx));
      chk("emit_rk", rk_o, exp_rk[idx]);
      chk("emit_busy", 128'(busy_o), 128'd1);
      chk("emit_done", 128'(done_o), 128'd0);
      got_rk[idx] = rk_o;
      if (stop_kind != 0 && idx == stop_at) begin
        rk_ready_i = 1'b1; start_i = 1'b1;
        if (stop_kind == 1) abort_i = 1'b1; else rst_ni = 1'b0;
        tick();
        abort_i = 1'b0; rst_ni = 1'b1; start_i = 1'b0; rk_ready_i = 1'b0;
        chk("stop_valid", 128'(rk_valid_o), 128'd0);
        chk("stop_done", 128'(done_o), 128'd0);
        chk("stop_busy", 128'(busy_o), 128'd0);
        if (stop_kind == 2) begin
          chk("rst_idx", 128'(rk_idx_o), 128'd0);
          chk("rst_rk", rk_o, 128'd0);
        end
        for (int k = 0; k < 3; k++) begin
          tick();
          chk("post_stop_valid", 128'(rk_valid_o), 128'd0);
          chk("post_stop_done", 128'(done_o), 128'd0);
        end
        fin = 1'b1;
      end else begin
        rdy = ($urandom_range(0, 99) < pct);
        rk_ready_i = rdy;
        if (idx == start_at && !pulsed) begin
          start_i = 1'b1; key_i = rnd128(); pulsed = 1'b1;
        end
        tick();
        start_i = 1'b0; rk_ready_i = 1'b0;
        if (rdy) begin
          if (idx == 10) begin
            chk("fin_valid", 128'(rk_valid_o), 128'd0);
            chk("fin_done", 128'(done_o), 128'd1);
            chk("fin_busy", 128'(busy_o), 128'd1);
            tick();
            chk("idle_done", 128'(done_o), 128'd0);
            chk("idle_busy", 128'(busy_o), 128'd0);
            chk("idle_valid", 128'(rk_valid_o), 128'd0);
            fin = 1'b1;
          end else begin
            idx++;
          end
        end
      end
      cyc++;
    end
    chk("run_completed", 128'(fin), 128'd1);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b1; abort_i = 1'b0; rk_ready_i = 1'b0; key_i = K_FIPS;
    tick(); tick();
    chk("rst_valid", 128'(rk_valid_o), 128'd0);
    chk("rst_done", 128'(done_o), 128'd0);
    chk("rst_busy", 128'(busy_o), 128'd0);
    chk("rst_idx", 128'(rk_idx_o), 128'd0);
    chk("rst_rk", rk_o, 128'd0);
    rst_ni = 1'b1; start_i = 1'b0;
    tick();
    chk("idle_valid", 128'(rk_valid_o), 128'd0);

    run(K_FIPS, 100, -1, 0, -1);
    chk("fips_rk0", got_rk[0], K_FIPS);
    chk("fips_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run(K_FIPS, 30, -1, 0, -1);
    chk("stall_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run(K_FIPS, 100, 5, 1, -1);
    run(K_SEQ, 100, -1, 0, -1);
    chk("seq_rk10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    run(K_FIPS, 60, -1, 0, 3);
    chk("startpulse_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run(K_FIPS, 100, 7, 2, -1);
    run(rnd128(), 50, -1, 0, -1);

    start_i = 1'b1; abort_i = 1'b1; key_i = rnd128();
    tick();
    chk("start_abort_valid", 128'(rk_valid_o), 128'd0);
    chk("start_abort_busy", 128'(busy_o), 128'd0);
    tick();
    chk("start_abort_valid2", 128'(rk_valid_o), 128'd0);
    start_i = 1'b0; abort_i = 1'b0;
    tick();

    for (int n = 0; n < 3; n++) run(rnd128(), $urandom_range(20, 100), -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes128_key_sched_ctrl.md
AES128_KEY_SCHED_CTRL -- requirements
Module: aes128_key_sched_ctrl

Interface
REQ-001 Parameters: none; round count fixed by package constant NUM_ROUNDS (10).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 start_i  input  1  request expansion of key_i; sampled only in IDLE.
REQ-005 abort_i  input  1  synchronous cancel of any expansion in progress.
REQ-006 key_i  input  128  cipher key, w0 in [127:96]; sampled on accepted start.
REQ-007 rk_ready_i  input  1  consumer accepts current round key.
REQ-008 rk_valid_o  output  1  rk_o/rk_idx_o hold a valid round key.
REQ-009 rk_o  output  128  round key, word 0 in [127:96].
REQ-010 rk_idx_o  output  4  round index 0..10 of rk_o.
REQ-011 busy_o  output  1  high in EMIT and DONE states.
REQ-012 done_o  output  1  one-cycle pulse after round-10 key accepted.

Function
REQ-013 States: IDLE, EMIT, DONE; encoding from package enum.
REQ-014 IDLE: start_i=1 and abort_i=0 -> latch key_i into key register, rk_idx_o<=0, go EMIT; rk_valid_o high the following cycle (latency 1).
REQ-015 EMIT: rk_valid_o=1, rk_o=key register, rk_idx_o=round counter.
REQ-016 Handshake: transfer occurs when rk_valid_o & rk_ready_i in same cycle.
REQ-017 rk_valid_o/rk_o/rk_idx_o hold stable while rk_valid_o=1 and rk_ready_i=0, for any number of cycles.
REQ-018 Transfer with rk_idx_o<10 -> key register <= next round key, counter +1, stay EMIT; back-to-back transfers give one key per cycle, 11 keys in 11 cycles minimum.
REQ-019 Next round key: t = SubWord(RotWord(w3)) ^ Rcon(idx+1); w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'; all 32-bit XOR, no carries.
REQ-020 Transfer with rk_idx_o=10 -> go DONE; rk_valid_o low next cycle.
REQ-021 DONE: done_o=1 for exactly one cycle, then IDLE unconditionally.
REQ-022 start_i in EMIT or DONE: ignored, no queueing.
REQ-023 abort_i=1 in any state: next cycle IDLE, rk_valid_o=0, done_o=0; abort wins over simultaneous start_i or transfer.
REQ-024 Counter never exceeds 10; no wrap-around; Rcon selector never 0 or >10.
REQ-025 rk_o outside EMIT: holds last key register value (don't-care for consumers).

Reset
REQ-026 rst_ni=0 at a clock edge: state IDLE, rk_valid_o=0, done_o=0, busy_o=0, rk_idx_o=0, rk_o=0, regardless of current state (incl. mid-expansion).
REQ-027 Reset has priority over start_i and abort_i.

Structure
REQ-028 S_BOX, SubWord, RotWord, Rcon taken from shared package myfunction; no local copies.
REQ-029 State enum typedef and NUM_ROUNDS constant added to myfunction.
REQ-030 One combinational sub-module aes128_key_step (inputs 128-bit key, 4-bit round; output next 128-bit key) implements REQ-019; controller holds only registers and FSM.

Verification
REQ-031 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready_i=1 -> idx0 = key, idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, done_o pulse 1 cycle after idx10 transfer.
REQ-032 Same key, rk_ready_i random 30% -> identical 11-key sequence; outputs stable during every stall.
REQ-033 abort_i at idx5 -> IDLE next cycle, no done_o; new start with key 000102030405060708090a0b0c0d0e0f -> idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-034 start_i pulsed at idx3 -> ignored, sequence unaltered.
REQ-035 rst_ni low at idx7 -> all outputs reset values next cycle; subsequent start works normally.
REQ-036 start_i and abort_i high together in IDLE -> remain IDLE, rk_valid_o stays 0.
